wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage between execute/load unit and the register file. Buffers up to two completed instructions in program order, merges returning load data into pending load entries, and drives one registered write per cycle into the register file. Holds off execute until the register file's 32-cycle post-reset clear sequence has finished. Reports pending-write hazards to decode.

## Interface
Parameters:
- DEPTH, 2, buffer entries; the design supports only the value 2.
- INIT_CYCLES, 32, post-reset cycles during which the register file is clearing itself.

Ports (clock and reset first):
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset; must be held across at least one rising clk edge.
- ex_valid  in  1  execute offers a completed instruction.
- ex_ready  out  1  stage accepts the offer; transfer on ex_valid & ex_ready at a rising edge.
- ex_rd  in  5  destination register.
- ex_data  in  32  ALU result; ignored when ex_is_load = 1.
- ex_is_load  in  1  entry waits for ld_data before retiring.
- ld_valid  in  1  one-cycle pulse carrying data for the oldest waiting load.
- ld_data  in  32  load result.
- rf_we  out  1  register-file write enable.
- rf_rd  out  5  register-file write address.
- rf_data  out  32  register-file write data.
- chk_rs1  in  5  decode source register 1 to check.
- chk_rs2  in  5  decode source register 2 to check.
- haz1  out  1  pending write to chk_rs1 (combinational).
- haz2  out  1  pending write to chk_rs2 (combinational).
- ld_err  out  1  sticky flag: ld_valid arrived with no waiting load at head.

## Operation
- Init counter: 6 bits, reset to 0. Increments each edge while below INIT_CYCLES. init_done = (count == INIT_CYCLES).
- ex_ready = init_done & (occupancy < 2). There is no pass-through when full.
- Buffer: 2-entry in-order FIFO. Each entry holds {rd, data, wait}, where wait = ex_is_load at accept.
- Load merge: if the head has wait = 1 and ld_valid = 1, the head's data <= ld_data and wait <= 0 at that edge. The head does not retire in the same cycle.
- ld_valid while the head is absent or has wait = 0: the pulse is discarded and ld_err <= 1 until reset.
- Retire: if the head is valid with wait = 0, it is popped at the edge.
  - Output registers load rf_we <= (rd != 0), rf_rd <= rd, rf_data <= data.
  - Otherwise rf_we <= 0. rf_rd and rf_data hold their values.
- Only the head may merge or retire. A second load waits behind the first.
- Simultaneous push and pop at occupancy 1: both happen and occupancy stays 1.
- haz1 = chk_rs1 != 0 and chk_rs1 matches the rd of any valid buffer entry, or matches rf_rd while rf_we = 1. haz2 is the same for chk_rs2.

## Timing
- Reset values:
  - ex_ready = 0, rf_we = 0, rf_rd = 0, rf_data = 0.
  - haz1 = haz2 = 0, ld_err = 0.
  - FIFO empty, init counter = 0.
- ex_ready first rises in the cycle after the 32nd rising edge following reset release.
- ALU entry accepted at edge E into an empty buffer: it retires at edge E+1, rf_we is high during cycle E+1..E+2, and the register file writes at edge E+2.
- Load entry at head, with ld_valid sampled at edge L: retires at L+1, and rf_we is high for the cycle after L+1.
- Sustained throughput: one retirement per cycle when no load is waiting.
- rf_we is high for exactly one cycle per retired entry with nonzero rd.
- Reset asserted mid-operation: all entries are dropped immediately, outputs return to reset values, and the init sequence restarts.

## Test plan
- Reset, then hold ex_valid = 1 -> ex_ready stays 0 for 32 edges, then rises. No rf_we before that.
- Back-to-back ALU entries (rd = 5, data = 0x11), (rd = 6, data = 0x22), (rd = 7, data = 0x33) -> three consecutive rf_we pulses with matching rd/data. ex_ready never drops.
- Load (rd = 3) followed by ALU (rd = 4, data = 0xAA), with ld_valid + ld_data = 0xDEADBEEF 5 cycles later:
  - ex_ready = 0 while the buffer is full.
  - Writes occur in order: rd = 3 with 0xDEADBEEF, then rd = 4 with 0xAA.
  - haz1 = 1 for chk_rs1 = 3 until its write completes.
- Entry with rd = 0, data = 0xFFFFFFFF -> retired with rf_we = 0. haz1 = 0 for chk_rs1 = 0.
- ld_valid pulse with an empty buffer -> ld_err = 1 and remains set; no rf_we.
- Reset asserted while two entries are pending -> outputs go to zero asynchronously, no writes issue, and the init delay of 32 cycles is repeated.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: a two-entry in-order buffer between execute/load and the register file.
// Loads wait at the head for ld_data. One registered write per cycle. Execute is held off until the register-file clear has finished.
module wb_stage #(
  parameter int DEPTH       = 2,
  parameter int INIT_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_data,
  input  logic        ex_is_load,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_data,
  input  logic [4:0]  chk_rs1,
  input  logic [4:0]  chk_rs2,
  output logic        haz1,
  output logic        haz2,
  output logic        ld_err
);

  // Handshake: an offer transfers at a rising edge where ex_valid and ex_ready are both high.
  // ex_ready does not depend on ex_valid, and execute must keep its fields stable until the transfer.

  localparam logic [5:0] INIT_LAST = 6'(INIT_CYCLES);

  logic [5:0]  init_cnt;
  logic        init_done;

  // Slot 0 is always the head. Slot 1 is valid only when slot 0 is valid.
  logic        v0, v1;
  logic        w0, w1;
  logic [4:0]  rd0, rd1;
  logic [31:0] d0, d1;

  logic [1:0]  occ;
  logic        push;
  logic        pop;
  logic        merge;
  logic        stray_ld;
  logic [31:0] new_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_cnt <= '0;
    end else if (init_cnt < INIT_LAST) begin
      init_cnt <= init_cnt + 6'd1;
    end
  end

  assign init_done = (init_cnt == INIT_LAST);

  assign occ      = {1'b0, v0} + {1'b0, v1};
  assign ex_ready = init_done && (occ < 2'(DEPTH));
  assign push     = ex_valid && ex_ready;
  assign pop      = v0 && !w0;
  assign merge    = v0 && w0 && ld_valid;
  assign stray_ld = ld_valid && !(v0 && w0);
  // Load entries carry no meaningful data until the merge.
  assign new_data = ex_is_load ? 32'd0 : ex_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0  <= 1'b0;
      w0  <= 1'b0;
      rd0 <= '0;
      d0  <= '0;
      v1  <= 1'b0;
      w1  <= 1'b0;
      rd1 <= '0;
      d1  <= '0;
    end else if (pop) begin
      if (push) begin
        // A push alongside a pop implies occupancy 1, so the new entry becomes the head.
        v0  <= 1'b1;
        w0  <= ex_is_load;
        rd0 <= ex_rd;
        d0  <= new_data;
      end else begin
        v0  <= v1;
        w0  <= w1;
        rd0 <= rd1;
        d0  <= d1;
        v1  <= 1'b0;
        w1  <= 1'b0;
      end
    end else begin
      if (merge) begin
        d0 <= ld_data;
        w0 <= 1'b0;
      end
      if (push) begin
        if (!v0) begin
          v0  <= 1'b1;
          w0  <= ex_is_load;
          rd0 <= ex_rd;
          d0  <= new_data;
        end else begin
          v1  <= 1'b1;
          w1  <= ex_is_load;
          rd1 <= ex_rd;
          d1  <= new_data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we   <= 1'b0;
      rf_rd   <= '0;
      rf_data <= '0;
    end else if (pop) begin
      rf_we   <= (rd0 != 5'd0);
      rf_rd   <= rd0;
      rf_data <= d0;
    end else begin
      rf_we   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_err <= 1'b0;
    end else if (stray_ld) begin
      ld_err <= 1'b1;
    end
  end

  // The in-flight register-file write counts as pending until it lands.
  always_comb begin
    haz1 = 1'b0;
    haz2 = 1'b0;
    if (chk_rs1 != 5'd0) begin
      haz1 = (v0 && (rd0 == chk_rs1)) || (v1 && (rd1 == chk_rs1)) ||
             (rf_we && (rf_rd == chk_rs1));
    end
    if (chk_rs2 != 5'd0) begin
      haz2 = (v0 && (rd0 == chk_rs2)) || (v1 && (rd1 == chk_rs2)) ||
             (rf_we && (rf_rd == chk_rs2));
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: expected register-file writes are queued at
// accept time and compared as rf_we pulses appear.
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd;
  logic [31:0] ex_data;
  logic        ex_is_load;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic        haz1;
  logic        haz2;
  logic        ld_err;

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];

  wb_stage #(.DEPTH(2), .INIT_CYCLES(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd),
    .ex_data(ex_data), .ex_is_load(ex_is_load),
    .ld_valid(ld_valid), .ld_data(ld_data),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
    .haz1(haz1), .haz2(haz2), .ld_err(ld_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [36:0] got, input logic [36:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // scoreboard: every rf_we pulse must match the oldest expected write
  always @(negedge clk) begin
    if (!rst && rf_we) begin
      if (exp_q.size() == 0) begin
        check("unexp_we", 37'd1, 37'd0);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("wr_rd", 37'(rf_rd), 37'(e[36:32]));
        check("wr_data", 37'(rf_data), 37'(e[31:0]));
      end
    end
  end

  // drivers: called at posedge+1, return at posedge+1 with ex_valid still high
  task automatic send(input logic [4:0] rd, input logic [31:0] data, input logic is_load,
                      input logic [31:0] ldv, output int waits);
    ex_valid   = 1'b1;
    ex_rd      = rd;
    ex_data    = data;
    ex_is_load = is_load;
    waits      = 0;
    @(negedge clk);
    while (!ex_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!ex_ready) check("send_timeout", 37'd1, 37'd0);
    else if (rd != 5'd0) exp_q.push_back({rd, is_load ? ldv : data});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid   = 1'b0;
    ex_is_load = 1'b0;
  endtask

  task automatic pulse_ld(input logic [31:0] v);
    ld_valid = 1'b1;
    ld_data  = v;
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at the negedge where reset drops: ex_ready must rise after exactly 32 edges.
  task automatic init_check(input string tag);
    int n;
    ex_valid   = 1'b1;
    ex_rd      = 5'd9;
    ex_data    = 32'h99;
    ex_is_load = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!ex_ready && n < 100);
    check(tag, 37'(n), 37'd32);
    exp_q.push_back({5'd9, 32'h99});
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    int w;
    logic [4:0]  r;
    logic [31:0] d, lv;

    rst = 1'b1; ex_valid = 1'b0; ex_rd = '0; ex_data = '0; ex_is_load = 1'b0;
    ld_valid = 1'b0; ld_data = '0; chk_rs1 = 5'd5; chk_rs2 = 5'd6;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 37'(ex_ready), 37'd0);
    check("rst_we", 37'(rf_we), 37'd0);
    check("rst_rd", 37'(rf_rd), 37'd0);
    check("rst_data", 37'(rf_data), 37'd0);
    check("rst_haz", 37'({haz1, haz2}), 37'd0);
    check("rst_lderr", 37'(ld_err), 37'd0);
    rst = 1'b0;
    init_check("init_len");
    wait_cycles(4);

    // back-to-back ALU entries
    send(5'd5, 32'h11, 1'b0, 32'h0, w); check("b2b_wait0", 37'(w), 37'd0);
    send(5'd6, 32'h22, 1'b0, 32'h0, w); check("b2b_wait1", 37'(w), 37'd0);
    send(5'd7, 32'h33, 1'b0, 32'h0, w); check("b2b_wait2", 37'(w), 37'd0);
    idle();
    @(negedge clk); check("b2b_we_a", 37'(rf_we), 37'd1);
    @(negedge clk); check("b2b_we_b", 37'(rf_we), 37'd1);
    wait_cycles(4);

    // load then ALU; the buffer stays full until the load data arrives
    chk_rs1 = 5'd3;
    send(5'd3, 32'h5555_0000, 1'b1, 32'hDEAD_BEEF, w);
    send(5'd4, 32'hAA, 1'b0, 32'h0, w);
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_ready", 37'(ex_ready), 37'd0);
      check("ld_haz_wait", 37'(haz1), 37'd1);
      @(posedge clk);
      #1;
    end
    ld_valid = 1'b1;
    ld_data  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    @(negedge clk); check("ld_haz_merged", 37'(haz1), 37'd1);
    @(negedge clk); check("ld_haz_writing", 37'(haz1), 37'd1);
    check("ld_we_rd3", 37'({rf_we, rf_rd}), 37'({1'b1, 5'd3}));
    @(negedge clk); check("ld_haz_done", 37'(haz1), 37'd0);
    check("ld_err_clean", 37'(ld_err), 37'd0);
    wait_cycles(3);

    // rd = 0 entry never writes and never flags a hazard
    chk_rs1 = 5'd0;
    send(5'd0, 32'hFFFF_FFFF, 1'b0, 32'h0, w);
    idle();
    @(negedge clk);
    check("rd0_we", 37'(rf_we), 37'd0);
    check("rd0_haz", 37'(haz1), 37'd0);
    wait_cycles(3);

    // random mix of ALU entries and served loads
    for (int i = 0; i < 20; i++) begin
      r  = 5'($urandom_range(0, 31));
      d  = $urandom;
      lv = $urandom;
      if ($urandom_range(0, 2) == 0) begin
        send(r, d, 1'b1, lv, w);
        idle();
        wait_cycles($urandom_range(0, 3));
        pulse_ld(lv);
      end else begin
        send(r, d, 1'b0, 32'h0, w);
        if ($urandom_range(0, 1) == 0) begin
          idle();
          wait_cycles($urandom_range(0, 2));
        end
      end
    end
    idle();
    wait_cycles(4);
    check("ld_err_after_rand", 37'(ld_err), 37'd0);

    // stray load pulse with an empty buffer
    pulse_ld(32'h1234);
    @(negedge clk); check("ld_err_set", 37'(ld_err), 37'd1);
    wait_cycles(3);
    @(negedge clk); check("ld_err_sticky", 37'(ld_err), 37'd1);
    wait_cycles(1);
    check("q_drain_pre", 37'(exp_q.size()), 37'd0);

    // reset with two loads pending: nothing from them may ever be written
    send(5'd12, 32'h0, 1'b1, 32'hC0DE_0012, w);
    send(5'd13, 32'h0, 1'b1, 32'hC0DE_0013, w);
    idle();
    chk_rs1 = 5'd12;
    @(negedge clk); check("pend_haz", 37'(haz1), 37'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_we", 37'(rf_we), 37'd0);
    check("arst_rd", 37'(rf_rd), 37'd0);
    check("arst_data", 37'(rf_data), 37'd0);
    check("arst_ready", 37'(ex_ready), 37'd0);
    check("arst_haz", 37'(haz1), 37'd0);
    check("arst_lderr", 37'(ld_err), 37'd0);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    init_check("reinit_len");
    wait_cycles(5);
    check("q_drain_end", 37'(exp_q.size()), 37'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
